// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;

  localparam int PC_W_DEF  = 8;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter; clear beats increment, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter / fetch sequencer: start, stall, branch and halt handling
// with a saturating retired-instruction counter.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             stall,
  input  logic             branch_en,
  input  logic             branch_rel,
  input  logic [PC_W-1:0]  branch_tgt,
  input  logic             halt_req,
  output logic [PC_W-1:0]  imem_addr,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             halt,
  output logic [CNT_W-1:0] instr_count
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            halt_q, halt_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            cnt_clr, cnt_inc;

  // Relative target: offset is two's complement, result wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] rel_target(input logic [PC_W-1:0] base,
                                                 input logic [PC_W-1:0] off);
    logic signed [PC_W:0] sum;
    sum = $signed({1'b0, base}) + $signed({off[PC_W-1], off});
    return sum[PC_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    halt_d  = halt_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (start) begin
      state_d = RUN;
      pc_d    = start_addr;
      halt_d  = 1'b0;
      cnt_clr = 1'b1;
    end else if ((state_q == RUN) && !stall) begin
      cnt_inc = 1'b1;
      if (halt_req) begin
        state_d = HALTED;
        halt_d  = 1'b1;
      end else if (branch_en) begin
        pc_d = branch_rel ? rel_target(pc_q, branch_tgt) : branch_tgt;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end
    fetch_valid_d = (state_d == RUN);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      halt_q        <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      halt_q        <= halt_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .CLK   (CLK),
    .RST_n (RST_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .q     (instr_count)
  );

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign halt        = halt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with hand-computed expected values.
module tb_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        start;
  logic [7:0]  start_addr;
  logic        stall;
  logic        branch_en;
  logic        branch_rel;
  logic [7:0]  branch_tgt;
  logic        halt_req;
  logic [7:0]  imem_addr;
  logic [7:0]  pc;
  logic        fetch_valid;
  logic        halt;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.PC_W(8), .CNT_W(16)) dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .start       (start),
    .start_addr  (start_addr),
    .stall       (stall),
    .branch_en   (branch_en),
    .branch_rel  (branch_rel),
    .branch_tgt  (branch_tgt),
    .halt_req    (halt_req),
    .imem_addr   (imem_addr),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .halt        (halt),
    .instr_count (instr_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_pc, input logic e_fv,
                         input logic e_halt, input logic [15:0] e_cnt);
    chk({tag, ".pc"}, {24'd0, pc}, {24'd0, e_pc});
    chk({tag, ".imem"}, {24'd0, imem_addr}, {24'd0, e_pc});
    chk({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, e_fv});
    chk({tag, ".halt"}, {31'd0, halt}, {31'd0, e_halt});
    chk({tag, ".cnt"}, {16'd0, instr_count}, {16'd0, e_cnt});
  endtask

  initial begin
    RST_n      = 1'b0;
    start      = 1'b0;
    start_addr = 8'h00;
    stall      = 1'b0;
    branch_en  = 1'b0;
    branch_rel = 1'b0;
    branch_tgt = 8'h00;
    halt_req   = 1'b0;

    // Reset state, then release between edges; block must stay idle.
    #23;
    chk_all("reset", 8'h00, 1'b0, 1'b0, 16'd0);
    RST_n = 1'b1;
    step();
    chk_all("idle_after_reset", 8'h00, 1'b0, 1'b0, 16'd0);

    // Test 1: start at 0, five sequential fetches.
    start = 1'b1; start_addr = 8'h00;
    step();
    start = 1'b0;
    chk_all("t1_start", 8'h00, 1'b1, 1'b0, 16'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_all($sformatf("t1_seq%0d", i), 8'(i), 1'b1, 1'b0, 16'(i));
    end

    // Test 2: PC wrap from FF to 00.
    start = 1'b1; start_addr = 8'hFE;
    step();
    start = 1'b0;
    chk_all("t2_start", 8'hFE, 1'b1, 1'b0, 16'd0);
    step(); chk_all("t2_ff", 8'hFF, 1'b1, 1'b0, 16'd1);
    step(); chk_all("t2_00", 8'h00, 1'b1, 1'b0, 16'd2);
    step(); chk_all("t2_01", 8'h01, 1'b1, 1'b0, 16'd3);

    // Held start reloads PC every edge and never counts.
    start = 1'b1; start_addr = 8'h20;
    step(); chk_all("hold_start_a", 8'h20, 1'b1, 1'b0, 16'd0);
    start_addr = 8'h30;
    step(); chk_all("hold_start_b", 8'h30, 1'b1, 1'b0, 16'd0);

    // Test 3: relative branch backwards by 4, then absolute branch.
    start_addr = 8'h10;
    step();
    start = 1'b0;
    chk_all("t3_start", 8'h10, 1'b1, 1'b0, 16'd0);
    branch_en = 1'b1; branch_rel = 1'b1; branch_tgt = 8'hFC;
    step(); chk_all("t3_rel", 8'h0C, 1'b1, 1'b0, 16'd1);
    branch_rel = 1'b0; branch_tgt = 8'h4B;
    step(); chk_all("t3_abs", 8'h4B, 1'b1, 1'b0, 16'd2);

    // Test 4: stall freezes everything and masks halt_req and branch.
    stall = 1'b1;
    step(); chk_all("t4_stall1", 8'h4B, 1'b1, 1'b0, 16'd2);
    halt_req = 1'b1;
    step(); chk_all("t4_stall2", 8'h4B, 1'b1, 1'b0, 16'd2);
    halt_req = 1'b0;
    step(); chk_all("t4_stall3", 8'h4B, 1'b1, 1'b0, 16'd2);
    stall = 1'b0; halt_req = 1'b1; branch_en = 1'b1; branch_tgt = 8'h99;
    step(); chk_all("t4_halt", 8'h4B, 1'b0, 1'b1, 16'd3);
    halt_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all($sformatf("t4_hold%0d", i), 8'h4B, 1'b0, 1'b1, 16'd3);
    end
    branch_en = 1'b0;

    // Test 5: restart from HALTED, then asynchronous reset mid-cycle.
    start = 1'b1; start_addr = 8'd75;
    step();
    start = 1'b0;
    chk_all("t5_restart", 8'd75, 1'b1, 1'b0, 16'd0);
    step(); chk_all("t5_run", 8'd76, 1'b1, 1'b0, 16'd1);
    #2;
    RST_n = 1'b0;
    #1;
    chk_all("t5_async_rst", 8'h00, 1'b0, 1'b0, 16'd0);
    RST_n = 1'b1;
    step(); chk_all("t5_no_resume", 8'h00, 1'b0, 1'b0, 16'd0);

    // Test 6: counter saturation.
    start = 1'b1; start_addr = 8'h00;
    step();
    start = 1'b0;
    repeat (65534) step();
    chk_all("t6_fffe", 8'hFE, 1'b1, 1'b0, 16'hFFFE);
    step(); chk_all("t6_ffff", 8'hFF, 1'b1, 1'b0, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("t6_sat%0d", i), 8'(i), 1'b1, 1'b0, 16'hFFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
